// File: rtl/reg_bank_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_arbiter_pkg
// Purpose : shared definitions for the two-requester register-bank arbiter:
//           FSM state codes, requester ids, data width type and the default
//           grant timeout.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package reg_bank_arbiter_pkg;

  // FSM state codes; also exported on the debug 'state' port.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Requester ids. B is the bitwise complement of A, so "the other
  // requester" is simply ~id.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Number of GRANT cycles allowed before a missing confirm expires the grant.
  localparam int TIMEOUT_CYC_DEFAULT = 8;

  typedef logic [3:0] data_t;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_bank_arbiter_if
// Purpose : requester-side handshake bundle between the two requesters (A and
//           B) and the arbiter.
// Signals : req_a/req_b       level requests, held until the matching ack
//           confirm_a/b       data-valid strobes, meaningful while granted
//           din_a/din_b       4-bit write data from each requester
//           gnt_a/gnt_b       grant outputs from the arbiter
//           ack_a/ack_b       write-complete outputs from the arbiter
// Modports: master - requester side (drives req/confirm/din)
//           slave  - arbiter side (drives gnt/ack)
// -----------------------------------------------------------------------------
interface reg_bank_arbiter_if;
  import reg_bank_arbiter_pkg::*;

  logic  req_a;
  logic  req_b;
  logic  confirm_a;
  logic  confirm_b;
  data_t din_a;
  data_t din_b;
  logic  gnt_a;
  logic  gnt_b;
  logic  ack_a;
  logic  ack_b;

  modport master (
    output req_a, req_b, confirm_a, confirm_b, din_a, din_b,
    input  gnt_a, gnt_b, ack_a, ack_b
  );

  modport slave (
    input  req_a, req_b, confirm_a, confirm_b, din_a, din_b,
    output gnt_a, gnt_b, ack_a, ack_b
  );

endinterface

// File: rtl/reg_bank_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purpose : combinational round-robin choice between two requesters.
// Ports   : req_a, req_b  (in)  current request levels
//           last          (in)  id of the requester that held the previous grant
//           any           (out) at least one request is present
//           pick          (out) id of the requester to grant (valid when any=1)
// -----------------------------------------------------------------------------
module rr_picker
  import reg_bank_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic any,
  output logic pick
);

  // A lone request wins outright; on a tie the requester that did not hold
  // the previous grant wins, which alternates service under contention.
  always_comb begin
    any  = req_a | req_b;
    pick = REQ_A;
    if (req_a && req_b) begin
      pick = ~last;
    end else if (req_b) begin
      pick = REQ_B;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bank_arbiter
// Purpose : arbitrates two requesters for write access to a pair of external
//           4-bit registers (A -> left register, B -> right register). A grant
//           waits for the owner's confirm, then produces a one-cycle write
//           enable followed by an ack held until the owner drops its request.
//           A grant not confirmed within TIMEOUT_CYC cycles expires.
// Params  : TIMEOUT_CYC  GRANT cycles allowed before confirm (legal 2..15)
// Ports   : clk          rising-edge clock
//           rst          asynchronous active-low reset
//           bus          requester handshake (slave modport)
//           we_left      one-cycle write enable for the left register
//           we_right     one-cycle write enable for the right register
//           dout         write data for both registers (last written value)
//           timeout      one-cycle pulse after a grant expires
//           state        current FSM state code (debug)
// -----------------------------------------------------------------------------
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  reg_bank_arbiter_if.slave   bus,
  output logic                we_left,
  output logic                we_right,
  output data_t               dout,
  output logic                timeout,
  output logic [1:0]          state
);

  // Final timer value of a grant; the timer counts 0..TIMER_LAST in GRANT.
  localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT_CYC - 1);

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [3:0] timer_q, timer_d;
  data_t      data_q, data_d;
  logic       timeout_q, timeout_d;

  logic       any_req;
  logic       picked;
  logic       owner_req;
  logic       owner_confirm;
  data_t      owner_din;

  rr_picker u_rr_picker (
    .req_a (bus.req_a),
    .req_b (bus.req_b),
    .last  (last_q),
    .any   (any_req),
    .pick  (picked)
  );

  // Only the current owner's request, confirm and data matter once a grant
  // is issued; the other requester's confirm is never looked at.
  always_comb begin
    owner_req     = (owner_q == REQ_A) ? bus.req_a     : bus.req_b;
    owner_confirm = (owner_q == REQ_A) ? bus.confirm_a : bus.confirm_b;
    owner_din     = (owner_q == REQ_A) ? bus.din_a     : bus.din_b;
  end

  // Next-state logic. In GRANT, confirm outranks both abort and timeout;
  // an abort (owner drops its request) outranks the timeout so a withdrawn
  // request never raises a timeout pulse. Every exit from GRANT records the
  // owner as 'last' so the next tie goes to the other requester.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    timer_d   = timer_q;
    data_d    = data_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = picked;
          timer_d = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (owner_confirm) begin
          data_d  = owner_din;
          last_d  = owner_q;
          timer_d = '0;
          state_d = ST_WRITE;
        end else if (!owner_req) begin
          last_d  = owner_q;
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          last_d    = owner_q;
          timer_d   = '0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      ST_WRITE: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. Reset leaves B as 'last' so A wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= REQ_A;
      last_q    <= REQ_B;
      timer_q   <= '0;
      data_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      data_q    <= data_d;
      timeout_q <= timeout_d;
    end
  end

  // Moore outputs decoded purely from registered state. The data register
  // is loaded on the same edge that enters WRITE, so dout only changes
  // together with a write enable and otherwise shows the last written value.
  always_comb begin
    bus.gnt_a = (state_q == ST_GRANT) && (owner_q == REQ_A);
    bus.gnt_b = (state_q == ST_GRANT) && (owner_q == REQ_B);
    bus.ack_a = (state_q == ST_DONE)  && (owner_q == REQ_A);
    bus.ack_b = (state_q == ST_DONE)  && (owner_q == REQ_B);
    we_left   = (state_q == ST_WRITE) && (owner_q == REQ_A);
    we_right  = (state_q == ST_WRITE) && (owner_q == REQ_B);
    dout      = data_q;
    timeout   = timeout_q;
    state     = state_q;
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_arbiter
// Purpose : self-checking bench for reg_bank_arbiter. Directed scenarios
//           followed by randomized traffic, all compared every cycle against
//           a transaction-level reference model, plus explicit spot checks.
// -----------------------------------------------------------------------------
module tb_reg_bank_arbiter;
  import reg_bank_arbiter_pkg::*;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we_left;
  logic       we_right;
  logic [3:0] dout;
  logic       timeout;
  logic [1:0] state;

  reg_bank_arbiter_if bus ();

  reg_bank_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .we_left  (we_left),
    .we_right (we_right),
    .dout     (dout),
    .timeout  (timeout),
    .state    (state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: who holds the bus and in which phase of a transaction.
  bit         m_granted;
  bit         m_writing;
  bit         m_acking;
  bit         m_expired;
  int         m_owner;
  int         m_last;
  int         m_age;
  logic [3:0] m_data;

  logic       ra = 1'b0;
  logic       rb = 1'b0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_granted = 0;
    m_writing = 0;
    m_acking  = 0;
    m_expired = 0;
    m_owner   = 0;
    m_last    = 1;
    m_age     = 0;
    m_data    = 4'h0;
  endtask

  // Advance the model by one clock using the inputs presented at the edge.
  task automatic model_step();
    logic oreq;
    logic oconf;
    oreq  = (m_owner == 0) ? bus.req_a : bus.req_b;
    oconf = (m_owner == 0) ? bus.confirm_a : bus.confirm_b;
    m_expired = 0;
    if (m_granted) begin
      if (oconf) begin
        m_data    = (m_owner == 0) ? bus.din_a : bus.din_b;
        m_last    = m_owner;
        m_granted = 0;
        m_writing = 1;
      end else if (!oreq) begin
        m_last    = m_owner;
        m_granted = 0;
      end else if (m_age == TO - 1) begin
        m_last    = m_owner;
        m_granted = 0;
        m_expired = 1;
      end else begin
        m_age++;
      end
    end else if (m_writing) begin
      m_writing = 0;
      m_acking  = 1;
    end else if (m_acking) begin
      if (!oreq) m_acking = 0;
    end else if (bus.req_a || bus.req_b) begin
      if (bus.req_a && bus.req_b) m_owner = 1 - m_last;
      else                        m_owner = bus.req_a ? 0 : 1;
      m_granted = 1;
      m_age     = 0;
    end
  endtask

  task automatic check_output();
    logic [3:0] exp_state;
    exp_state = m_granted ? 4'd1 : m_writing ? 4'd2 : m_acking ? 4'd3 : 4'd0;
    check_bit("gnt_a",    bus.gnt_a, m_granted && m_owner == 0);
    check_bit("gnt_b",    bus.gnt_b, m_granted && m_owner == 1);
    check_bit("ack_a",    bus.ack_a, m_acking  && m_owner == 0);
    check_bit("ack_b",    bus.ack_b, m_acking  && m_owner == 1);
    check_bit("we_left",  we_left,   m_writing && m_owner == 0);
    check_bit("we_right", we_right,  m_writing && m_owner == 1);
    check_bit("timeout",  timeout,   m_expired);
    check_vec("dout",     dout,      m_data);
    check_vec("state",    {2'b00, state}, exp_state);
  endtask

  task automatic apply_stimulus(input logic req_a, input logic req_b,
                                input logic conf_a, input logic conf_b,
                                input logic [3:0] d_a, input logic [3:0] d_b);
    bus.req_a     = req_a;
    bus.req_b     = req_b;
    bus.confirm_a = conf_a;
    bus.confirm_b = conf_b;
    bus.din_a     = d_a;
    bus.din_b     = d_b;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_output();
  endtask

  // Pull reset low between clock edges and check that everything clears
  // before the next rising edge, then release it on a falling edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_bit({tag, "_gnt_a"}, bus.gnt_a, 1'b0);
    check_bit({tag, "_ack_a"}, bus.ack_a, 1'b0);
    check_bit({tag, "_we_left"}, we_left, 1'b0);
    check_output();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
    model_reset();
    #2;
    check_output();
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] single requester A");
    apply_stimulus(1, 0, 0, 0, 4'h0, 4'h0);
    tick();
    check_bit("single_gnt_a", bus.gnt_a, 1'b1);
    apply_stimulus(1, 0, 1, 0, 4'hA, 4'h0);
    tick();
    check_bit("single_we_left", we_left, 1'b1);
    check_bit("single_we_right", we_right, 1'b0);
    check_vec("single_dout", dout, 4'hA);
    apply_stimulus(1, 0, 0, 0, 4'h0, 4'h0);
    tick();
    check_bit("single_ack_a", bus.ack_a, 1'b1);
    tick();
    check_bit("single_ack_held", bus.ack_a, 1'b1);
    apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
    tick();
    tick();

    $display("[TB] tie after reset");
    do_reset("tie_rst");
    apply_stimulus(1, 1, 0, 0, 4'h0, 4'h0);
    tick();
    check_bit("tie_gnt_a", bus.gnt_a, 1'b1);
    check_bit("tie_no_gnt_b", bus.gnt_b, 1'b0);
    apply_stimulus(1, 1, 1, 0, 4'h3, 4'h0);
    tick();
    apply_stimulus(0, 1, 0, 0, 4'h0, 4'h0);
    tick();
    tick();
    tick();
    check_bit("tie_gnt_b", bus.gnt_b, 1'b1);
    apply_stimulus(0, 1, 0, 1, 4'h0, 4'h5);
    tick();
    check_bit("tie_we_right", we_right, 1'b1);
    check_vec("tie_dout", dout, 4'h5);
    apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
    tick();
    check_bit("tie_ack_b", bus.ack_b, 1'b1);
    tick();
    check_vec("tie_dout_held", dout, 4'h5);

    $display("[TB] timeout on B with A pending");
    apply_stimulus(0, 1, 0, 0, 4'h0, 4'h0);
    tick();
    check_bit("to_gnt_b_0", bus.gnt_b, 1'b1);
    apply_stimulus(1, 1, 0, 0, 4'h0, 4'h0);
    for (int i = 1; i < TO; i++) begin
      tick();
      check_bit("to_gnt_b_held", bus.gnt_b, 1'b1);
      check_bit("to_no_early_pulse", timeout, 1'b0);
    end
    tick();
    check_bit("to_pulse", timeout, 1'b1);
    check_bit("to_gnt_b_dropped", bus.gnt_b, 1'b0);
    check_vec("to_idle", {2'b00, state}, 4'd0);
    tick();
    check_bit("to_pulse_end", timeout, 1'b0);
    check_bit("to_gnt_a_next", bus.gnt_a, 1'b1);

    $display("[TB] ignored confirm and abort");
    apply_stimulus(1, 1, 0, 1, 4'h0, 4'h9);
    tick();
    check_bit("ign_no_we_right", we_right, 1'b0);
    check_bit("ign_still_gnt_a", bus.gnt_a, 1'b1);
    apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
    tick();
    check_bit("abort_no_ack", bus.ack_a, 1'b0);
    check_bit("abort_no_timeout", timeout, 1'b0);
    check_vec("abort_idle", {2'b00, state}, 4'd0);
    tick();

    $display("[TB] confirm on final grant cycle");
    apply_stimulus(1, 0, 0, 0, 4'h0, 4'h0);
    tick();
    for (int i = 1; i < TO; i++) tick();
    apply_stimulus(1, 0, 1, 0, 4'hC, 4'h0);
    tick();
    check_bit("late_we_left", we_left, 1'b1);
    check_bit("late_no_timeout", timeout, 1'b0);
    check_vec("late_dout", dout, 4'hC);
    apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
    tick();
    check_bit("late_no_timeout2", timeout, 1'b0);
    tick();

    $display("[TB] reset during write");
    apply_stimulus(1, 0, 0, 0, 4'h0, 4'h0);
    tick();
    apply_stimulus(1, 0, 1, 0, 4'h7, 4'h0);
    tick();
    check_bit("mid_we_left", we_left, 1'b1);
    apply_stimulus(1, 1, 0, 0, 4'h0, 4'h0);
    do_reset("mid_rst");
    tick();
    check_bit("mid_tie_gnt_a", bus.gnt_a, 1'b1);
    apply_stimulus(0, 0, 0, 0, 4'h0, 4'h0);
    tick();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) ra = ~ra;
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      apply_stimulus(ra, rb, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     4'($urandom), 4'($urandom));
      tick();
      check_bit("rand_we_exclusive", we_left && we_right, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 8: GRANT cycles allowed before confirm; legal range 2..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_a  input  1  requester A wants the left register; level, held until ack_a.
REQ-005 req_b  input  1  requester B wants the right register; level, held until ack_b.
REQ-006 confirm_a  input  1  requester A data valid on din_a while gnt_a=1.
REQ-007 confirm_b  input  1  requester B data valid on din_b while gnt_b=1.
REQ-008 din_a  input  4  requester A data.
REQ-009 din_b  input  4  requester B data.
REQ-010 gnt_a  output  1  grant to A; high only in GRANT with owner=A.
REQ-011 gnt_b  output  1  grant to B; high only in GRANT with owner=B.
REQ-012 ack_a  output  1  A's write complete; high in DONE with owner=A.
REQ-013 ack_b  output  1  B's write complete; high in DONE with owner=B.
REQ-014 we_left  output  1  one-cycle write enable to the left 4-bit register.
REQ-015 we_right  output  1  one-cycle write enable to the right 4-bit register.
REQ-016 dout  output  4  data to both registers; valid when either we_* is high.
REQ-017 timeout  output  1  one-cycle pulse when a grant expires without confirm.
REQ-018 state  output  2  current FSM state code, for debug.

Function
REQ-019 All outputs are Moore: decoded from registered state, owner, and data only.
REQ-020 FSM states and codes: IDLE=0, GRANT=1, WRITE=2, DONE=3.
REQ-021 IDLE, no req: stay in IDLE.
REQ-022 IDLE, exactly one req: owner set to that requester; next state GRANT.
REQ-023 IDLE, both req: owner set to the requester not equal to last; next state GRANT.
REQ-024 GRANT: the timer counts cycles spent in GRANT, starting at 0 on entry.
REQ-025 GRANT, confirm of owner high: latch the owner's din into the data register; next state WRITE.
REQ-026 GRANT, owner's req low and no confirm: abort; next state IDLE; no write, no ack.
REQ-027 GRANT, timer = TIMEOUT_CYC-1 and no confirm: next state IDLE; timeout=1 for the following cycle.
REQ-028 Confirm has priority over timeout and over abort in the same cycle.
REQ-029 Confirm from the non-owner is ignored in every state.
REQ-030 WRITE: lasts exactly one cycle; we_left=1 if owner=A, else we_right=1; dout=latched data; next state DONE.
REQ-031 DONE: ack of owner held high until owner's req is low; then next state IDLE.
REQ-032 last <= owner on every exit from GRANT (write, abort or timeout), giving round-robin fairness.
REQ-033 Latency: req seen in IDLE -> gnt next cycle; confirm -> we_* next cycle -> ack the cycle after.
REQ-034 dout holds the last written value between writes; we_left and we_right are never high together.

Reset
REQ-035 rst low: immediately state=IDLE, owner=A, last=B (A wins first tie), timer=0, data=0.
REQ-036 During reset all outputs are 0, state=0; a mid-transaction reset drops gnt/ack with no write.
REQ-037 Operation resumes on the first rising clk edge after rst goes high.

Structure
REQ-038 The shared package holds the state codes (IDLE, GRANT, WRITE, DONE), the requester ids A=0 and B=1, and the TIMEOUT_CYC default.
REQ-039 One sub-module, rr_picker, is combinational: inputs req_a, req_b, last; outputs any and pick.
REQ-040 The left and right registers stay outside this block; the parent connects we_left/we_right/dout to them.

Verification
REQ-041 Single A: req_a=1, confirm_a with din_a=4'hA one cycle after gnt_a -> we_left=1, dout=A; ack_a next cycle; no we_right.
REQ-042 Tie after reset: req_a=req_b=1 -> gnt_a first; after A completes and drops req -> gnt_b; B writes din_b=5 to right.
REQ-043 Timeout: req_b=1, never confirm -> gnt_b high 8 cycles, timeout pulse, IDLE; with req_a pending, gnt_a granted next.
REQ-044 Abort/ignore: confirm_b while owner=A -> no write; req_a dropped in GRANT -> IDLE, no ack, no timeout.
REQ-045 Reset mid-WRITE/DONE: rst low asynchronously -> all outputs 0 same cycle; after release, tie grants A.
REQ-046 Confirm on the final timeout cycle -> write happens, no timeout pulse.
